// File: rtl/tcon_src_pkg.sv
// rtl/tcon_src_pkg.sv - shared types and timing helpers for the TCON pattern source
package tcon_src_pkg;

  // Width of the line/pixel counters; comfortably covers 1366x768 class timings
  localparam int CW = 16;

  typedef enum logic [2:0] {
    PAT_SOLID   = 3'd0,
    PAT_HRAMP   = 3'd1,
    PAT_VRAMP   = 3'd2,
    PAT_BARS    = 3'd3,
    PAT_CHECKER = 3'd4,
    PAT_INDEX   = 3'd5
  } pat_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st_t;

  function automatic int htot(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int vtot(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/tcon_pattern_gen.sv
// rtl/tcon_pattern_gen.sv - combinational test pattern pixel generator
// Pattern codes 6 and 7 fall through to the solid colour.
module tcon_pattern_gen
  import tcon_src_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]      pat,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   y,
  input  logic [3*DW-1:0] p,
  input  logic [2:0]      bar_idx,
  input  logic [3*DW-1:0] solid_rgb,
  output logic [DW-1:0]   r,
  output logic [DW-1:0]   g,
  output logic [DW-1:0]   b
);

  localparam logic [DW-1:0] FULL = {DW{1'b1}};

  always_comb begin
    r = solid_rgb[3*DW-1:2*DW];
    g = solid_rgb[2*DW-1:DW];
    b = solid_rgb[DW-1:0];
    case (pat)
      PAT_HRAMP: begin
        r = x;
        g = x;
        b = x;
      end
      PAT_VRAMP: begin
        r = y;
        g = y;
        b = y;
      end
      PAT_BARS: begin
        // W,Y,C,G,M,R,B,K: each primary is on for a fixed half of the bar indices
        r = bar_idx[1] ? '0 : FULL;
        g = bar_idx[2] ? '0 : FULL;
        b = bar_idx[0] ? '0 : FULL;
      end
      PAT_CHECKER: begin
        r = (x[3] ^ y[3]) ? FULL : '0;
        g = (x[3] ^ y[3]) ? FULL : '0;
        b = (x[3] ^ y[3]) ? FULL : '0;
      end
      PAT_INDEX: begin
        r = p[DW-1:0];
        g = p[2*DW-1:DW];
        b = p[3*DW-1:2*DW];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tcon_timing_pattern_src.sv
// rtl/tcon_timing_pattern_src.sv - vsync/hsync/de timing and RGB test pattern source
// Counters and FSM run one clock ahead; every output pin is a registered image of them.
module tcon_timing_pattern_src
  import tcon_src_pkg::*;
#(
  parameter int DW     = 8,
  parameter int WIDTH  = 1366,
  parameter int HEIGHT = 768,
  parameter int H_SYNC = 32,
  parameter int H_BP   = 48,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 12,
  parameter int V_FP   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [2:0]      pat_sel,
  input  logic [3*DW-1:0] solid_rgb,
  output logic            vsync,
  output logic            hsync,
  output logic            de,
  output logic [DW-1:0]   r_out,
  output logic [DW-1:0]   g_out,
  output logic [DW-1:0]   b_out,
  output logic            frame_done,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam int HTOT = htot(H_SYNC, H_BP, WIDTH, H_FP);
  localparam int VTOT = vtot(V_SYNC, V_BP, HEIGHT, V_FP);
  localparam int BW   = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

  localparam logic [CW-1:0] H_LAST  = CW'(HTOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(VTOT - 1);
  localparam logic [CW-1:0] H_SYNCW = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNCW = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT0  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT1  = CW'(H_SYNC + H_BP + WIDTH);
  localparam logic [CW-1:0] V_ACT0  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT1  = CW'(V_SYNC + V_BP + HEIGHT);
  localparam logic [CW-1:0] BW_M1   = CW'(BW - 1);

  st_t             st;
  logic [CW-1:0]   hcnt;
  logic [CW-1:0]   vcnt;
  logic [2:0]      pat_q;
  logic [3*DW-1:0] solid_q;
  logic [3*DW-1:0] p_cnt;
  logic [CW-1:0]   bar_sub;
  logic [2:0]      bar_idx;

  logic            run;
  logic            h_last;
  logic            frame_last;
  logic            active;
  logic [DW-1:0]   x_lo;
  logic [DW-1:0]   y_lo;
  logic [DW-1:0]   pix_r;
  logic [DW-1:0]   pix_g;
  logic [DW-1:0]   pix_b;

  assign run        = (st == ST_RUN);
  assign h_last     = (hcnt == H_LAST);
  assign frame_last = run && h_last && (vcnt == V_LAST);
  assign active     = run && (hcnt >= H_ACT0) && (hcnt < H_ACT1)
                          && (vcnt >= V_ACT0) && (vcnt < V_ACT1);
  // Only the low DW bits of the coordinates feed any pattern
  assign x_lo = hcnt[DW-1:0] - H_ACT0[DW-1:0];
  assign y_lo = vcnt[DW-1:0] - V_ACT0[DW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= ST_IDLE;
      hcnt    <= '0;
      vcnt    <= '0;
      pat_q   <= '0;
      solid_q <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (en) begin
            st      <= ST_RUN;
            hcnt    <= '0;
            vcnt    <= '0;
            pat_q   <= pat_sel;
            solid_q <= solid_rgb;
          end
        end
        ST_RUN: begin
          if (frame_last) begin
            hcnt <= '0;
            vcnt <= '0;
            // en is only looked at here, so a started frame always completes
            if (en) begin
              pat_q   <= pat_sel;
              solid_q <= solid_rgb;
            end else begin
              st <= ST_IDLE;
            end
          end else if (h_last) begin
            hcnt <= '0;
            vcnt <= vcnt + CW'(1);
          end else begin
            hcnt <= hcnt + CW'(1);
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Pixel index and bar position are running counters rather than multiplies/divides
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_cnt   <= '0;
      bar_sub <= '0;
      bar_idx <= '0;
    end else begin
      if (!run || (vcnt < V_ACT0)) begin
        p_cnt <= '0;
      end else if (active) begin
        p_cnt <= p_cnt + (3*DW)'(1);
      end

      if (!active) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (bar_sub == BW_M1) begin
        bar_sub <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + CW'(1);
      end
    end
  end

  tcon_pattern_gen #(
    .DW(DW)
  ) u_pattern_gen (
    .pat      (pat_q),
    .x        (x_lo),
    .y        (y_lo),
    .p        (p_cnt),
    .bar_idx  (bar_idx),
    .solid_rgb(solid_q),
    .r        (pix_r),
    .g        (pix_g),
    .b        (pix_b)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync      <= 1'b0;
      hsync      <= 1'b0;
      de         <= 1'b0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync      <= run && (vcnt < V_SYNCW);
      hsync      <= run && (hcnt < H_SYNCW);
      de         <= active;
      r_out      <= active ? pix_r : '0;
      g_out      <= active ? pix_g : '0;
      b_out      <= active ? pix_b : '0;
      frame_done <= frame_last;
      busy       <= run;
      if (frame_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tcon_timing_pattern_src.sv
// tb/tb_tcon_timing_pattern_src.sv - self-checking bench for tcon_timing_pattern_src
module tb_tcon_timing_pattern_src;

  localparam int DW  = 8;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int HS  = 2;
  localparam int HBP = 2;
  localparam int HFP = 2;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int HT  = HS + HBP + W + HFP;
  localparam int VT  = VS + VBP + H + VFP;
  localparam int FT  = HT * VT;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    pat_sel = '0;
  logic [23:0]   solid_rgb = '0;
  logic          vsync, hsync, de, frame_done, busy;
  logic [7:0]    r_out, g_out, b_out;
  logic [15:0]   frame_cnt;

  tcon_timing_pattern_src #(
    .DW(DW), .WIDTH(W), .HEIGHT(H), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
    .vsync(vsync), .hsync(hsync), .de(de), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame position as one clock index into the frame
  bit          m_run;
  int          m_k;
  int          m_pat;
  logic [23:0] m_sol;
  bit          e_vs, e_hs, e_de, e_fd, e_busy;
  logic [23:0] e_rgb;
  logic [15:0] e_fcnt;

  function automatic logic [23:0] bar_col(input int bi);
    case (bi)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pix(input int pat, input logic [23:0] sol, input int x, input int y);
    logic [7:0]  v;
    logic [23:0] pv;
    int bi;
    case (pat)
      1: begin v = 8'(x); return {v, v, v}; end
      2: begin v = 8'(y); return {v, v, v}; end
      3: begin bi = x / (W / 8); if (bi > 7) bi = 7; return bar_col(bi); end
      4: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      5: begin pv = 24'(y * W + x); return {pv[7:0], pv[15:8], pv[23:16]}; end
      default: return sol;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_k = 0; m_pat = 0; m_sol = '0;
    e_vs = 0; e_hs = 0; e_de = 0; e_fd = 0; e_busy = 0; e_rgb = '0; e_fcnt = '0;
  endtask

  task automatic model_edge();
    int line, col, x, y;
    if (!rstn) begin
      model_reset();
      return;
    end
    e_vs = 0; e_hs = 0; e_de = 0; e_fd = 0; e_rgb = '0;
    e_busy = m_run;
    if (m_run) begin
      line = m_k / HT;
      col  = m_k % HT;
      x = col - (HS + HBP);
      y = line - (VS + VBP);
      e_vs = (line < VS);
      e_hs = (col < HS);
      e_de = (x >= 0) && (x < W) && (y >= 0) && (y < H);
      if (e_de) e_rgb = pix(m_pat, m_sol, x, y);
      e_fd = (m_k == FT - 1);
      if (e_fd) e_fcnt = e_fcnt + 16'd1;
    end
    if (!m_run) begin
      if (en) begin m_run = 1; m_k = 0; m_pat = int'(pat_sel); m_sol = solid_rgb; end
    end else if (m_k == FT - 1) begin
      m_k = 0;
      if (en) begin m_pat = int'(pat_sel); m_sol = solid_rgb; end
      else m_run = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("vsync", vsync, e_vs);
    chk("hsync", hsync, e_hs);
    chk("de", de, e_de);
    chk("rgb", {r_out, g_out, b_out}, e_rgb);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
    chk("frame_cnt", frame_cnt, e_fcnt);
  endtask

  task automatic drain();
    int n = 0;
    en = 0;
    while ((busy || m_run) && n < 300) begin cyc(); n++; end
    chk("drain_bound", n < 300, 1);
  endtask

  typedef struct {
    int          pat;
    logic [23:0] sol;
    int          idx;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] cap[32];

  task automatic add(input int pat, input logic [23:0] sol, input int idx, input logic [23:0] exp);
    vec_t v;
    v.pat = pat; v.sol = sol; v.idx = idx; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_frame(input int pat, input logic [23:0] sol);
    int n = 0;
    int cnt = 0;
    pat_sel = 3'(pat);
    solid_rgb = sol;
    en = 1;
    cyc();
    en = 0;
    while (n < 200) begin
      cyc(); n++;
      if (de) begin
        if (cnt < 32) cap[cnt] = {r_out, g_out, b_out};
        cnt++;
      end
      if (!busy && n > 2) break;
    end
    chk("tbl_pixel_count", cnt, 32);
  endtask

  initial begin
    int n, vs_e, hs_e, de_e, vs_n, de_n, fd_n, fd_t0, fd_t1, bf, prev_pat;
    logic [23:0] prev_sol;
    logic [15:0] fc0;
    logic [7:0]  last_r;

    model_reset();
    repeat (3) cyc();
    chk("reset_busy", busy, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    rstn = 1;
    cyc();

    // Latency: edge 1 samples en
    pat_sel = 1; en = 1;
    n = 0; vs_e = -1; hs_e = -1; de_e = -1;
    while (n < 40) begin
      cyc(); n++;
      if (vsync && vs_e < 0) vs_e = n;
      if (hsync && hs_e < 0) hs_e = n;
      if (de && de_e < 0) de_e = n;
    end
    chk("lat_vsync", vs_e, 2);
    chk("lat_hsync", hs_e, 2);
    chk("lat_de", de_e, 2 + (VS + VBP) * HT + HS + HBP);
    drain();

    // Two back-to-back frames
    fc0 = frame_cnt; en = 1;
    n = 0; vs_n = 0; de_n = 0; fd_n = 0; fd_t0 = 0; fd_t1 = 0;
    while (n < 400) begin
      cyc(); n++;
      if (vsync) vs_n++;
      if (de) de_n++;
      if (frame_done) begin
        if (fd_n == 0) begin fd_t0 = n; en = 0; end else fd_t1 = n;
        fd_n++;
      end
      if (fd_n == 2 && !busy) break;
    end
    chk("timing_vsync_clks", vs_n, 2 * VS * HT);
    chk("timing_de_clks", de_n, 2 * W * H);
    chk("timing_frame_done_cnt", fd_n, 2);
    chk("timing_frame_period", fd_t1 - fd_t0, FT);
    chk("timing_frame_cnt_delta", 16'(frame_cnt - fc0), 2);
    drain();

    // Pattern vectors
    add(3, 24'h0, 0, 24'hFFFFFF); add(3, 24'h0, 1, 24'hFFFF00);
    add(3, 24'h0, 2, 24'h00FFFF); add(3, 24'h0, 3, 24'h00FF00);
    add(3, 24'h0, 4, 24'hFF00FF); add(3, 24'h0, 5, 24'hFF0000);
    add(3, 24'h0, 6, 24'h0000FF); add(3, 24'h0, 7, 24'h000000);
    add(3, 24'h0, 10, 24'h00FFFF);
    add(1, 24'h0, 0, 24'h000000); add(1, 24'h0, 7, 24'h070707); add(1, 24'h0, 13, 24'h050505);
    add(2, 24'h0, 0, 24'h000000); add(2, 24'h0, 9, 24'h010101); add(2, 24'h0, 31, 24'h030303);
    add(5, 24'h0, 0, 24'h000000); add(5, 24'h0, 17, 24'h110000); add(5, 24'h0, 31, 24'h1F0000);
    add(0, 24'h123456, 3, 24'h123456);
    add(6, 24'hABCDEF, 20, 24'hABCDEF);
    add(7, 24'h0F0F0F, 0, 24'h0F0F0F);
    add(4, 24'hFFFFFF, 5, 24'h000000);
    prev_pat = -1; prev_sol = '0;
    foreach (tbl[i]) begin
      if (tbl[i].pat != prev_pat || tbl[i].sol != prev_sol) begin
        run_frame(tbl[i].pat, tbl[i].sol);
        prev_pat = tbl[i].pat; prev_sol = tbl[i].sol;
      end
      chk($sformatf("tbl%0d_pat%0d_pix%0d", i, tbl[i].pat, tbl[i].idx), cap[tbl[i].idx], tbl[i].exp);
    end

    // Stop and pattern switch mid-frame at hcnt=5 of line 3
    pat_sel = 1; solid_rgb = '0; en = 1; n = 0;
    do begin cyc(); n++; end while (!(m_run && m_k == 3 * HT + 5) && n < 200);
    chk("stop_reach_bound", n < 200, 1);
    en = 0; pat_sel = 2;
    n = 0; fd_t0 = -1; bf = -1; last_r = '0;
    while (n < 200) begin
      cyc(); n++;
      if (de) last_r = r_out;
      if (frame_done) fd_t0 = n;
      if (fd_t0 >= 0 && !busy) begin bf = n; break; end
    end
    chk("stop_busy_fall", bf - fd_t0, 1);
    chk("stop_last_pixel_old_pattern", last_r, 8'd7);
    vs_n = 0;
    repeat (30) begin cyc(); if (vsync) vs_n++; end
    chk("stop_no_vsync", vs_n, 0);

    // Randomised run against the model
    repeat (800) begin
      en = ($urandom_range(0, 9) < 7);
      pat_sel = 3'($urandom_range(0, 7));
      solid_rgb = 24'($urandom);
      cyc();
    end
    drain();

    // Asynchronous reset in the middle of an active line
    pat_sel = 5; en = 1; n = 0;
    do begin cyc(); n++; end while (!(m_run && m_k == 2 * HT + 6) && n < 300);
    chk("rst_reach_bound", n < 300, 1);
    chk("rst_pre_de", de, 1);
    #2 rstn = 0;
    #1;
    chk("rst_async_vsync", vsync, 0);
    chk("rst_async_hsync", hsync, 0);
    chk("rst_async_de", de, 0);
    chk("rst_async_rgb", {r_out, g_out, b_out}, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_frame_cnt", frame_cnt, 0);
    model_reset();
    repeat (2) cyc();
    rstn = 1;
    n = 0; vs_e = -1;
    while (n < 10) begin cyc(); n++; if (vsync && vs_e < 0) vs_e = n; end
    chk("rst_restart_vsync", vs_e, 2);
    drain();
    chk("rst_frame_cnt", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
